// File: rtl/measurement_sequencer.sv
// measurement_sequencer
//   Sequences one voltmeter measurement. A start request arms the block,
//   the first zero-crossing rising edge opens the integration window, and
//   the window stays open until the external 24-cycle line counter reports
//   finished. An abort or a watchdog timeout flushes the counter round to
//   its wrap point so it always ends in a clean zero state.
//
//   Optional feature macro: MEAS_SEQ_WATCHDOG_EN (watchdog present when
//   defined; otherwise err_o is tied low and ARM/INTEGRATE wait forever).
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   start_i                 start request (taken in IDLE only)
//   abort_i                 abort request (taken in ARM / INTEGRATE only)
//   irq_ack_i               clears the sticky done_o / err_o flags
//   zero_cross_i            synchronized comparator level
//   cnt_count_i[4:0]        line-cycle counter value (0..24)
//   cnt_finished_i          line-cycle counter finished flag
//   cnt_increment_o         one-clock counter advance pulse
//   cnt_clear_o             one-clock finished-flag clear pulse
//   integrate_o             integration window enable
//   busy_o                  not in IDLE
//   done_o, err_o           sticky completion / timeout flags
module measurement_sequencer #(
    parameter int WDOG_W     = 20,
    parameter int WDOG_LIMIT = 1000000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic       irq_ack_i,
    input  logic       zero_cross_i,
    input  logic [4:0] cnt_count_i,
    input  logic       cnt_finished_i,
    output logic       cnt_increment_o,
    output logic       cnt_clear_o,
    output logic       integrate_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o
);

    localparam logic [4:0] CNT_FULL = 5'd24;

    // Limit must be a non-zero value representable in the watchdog counter.
    if (WDOG_LIMIT < 1 || longint'(WDOG_LIMIT) >= (longint'(1) << WDOG_W)) begin : g_bad_wdog_cfg
        $error("measurement_sequencer: WDOG_LIMIT does not fit in WDOG_W bits");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_INTEG,
        S_FLUSH,
        S_CLEAR
    } state_t;

    state_t state_q, state_d;
    logic   zc_q;
    logic   rise;
    logic   arm_entry;
    logic   wdog_take;
    logic   ok_q, ok_d;
    logic   inc_q, inc_d;
    logic   clr_q, clr_d;
    logic   integ_q, integ_d;
    logic   busy_q, busy_d;
    logic   done_q, done_d;

    assign rise      = zero_cross_i & ~zc_q;
    assign arm_entry = (state_q == S_IDLE) && start_i;

`ifdef MEAS_SEQ_WATCHDOG_EN
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_LIMIT - 1);

    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              wdog_hit;
    logic              err_q, err_d;

    always_comb begin
        // The limit is reached on the clock that would advance the count to
        // WDOG_LIMIT; a rise in that clock restarts the window instead.
        wdog_hit  = ((state_q == S_ARM) || (state_q == S_INTEG)) && !rise
                    && (wdog_q == WDOG_LAST);
        // Finishing in INTEGRATE outranks a coincident timeout.
        wdog_take = wdog_hit && !((state_q == S_INTEG) && cnt_finished_i);

        wdog_d = wdog_q;
        if (arm_entry) begin
            wdog_d = '0;
        end else if ((state_q == S_ARM) || (state_q == S_INTEG)) begin
            if (rise) begin
                wdog_d = '0;
            end else if (wdog_q != WDOG_LAST) begin
                wdog_d = wdog_q + WDOG_W'(1);
            end
        end

        err_d = err_q;
        if (wdog_take) begin
            err_d = 1'b1;
        end else if (irq_ack_i || arm_entry) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign wdog_take = 1'b0;
    assign err_o     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ok_d    = ok_q;
        inc_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_ARM;
            end
            S_ARM: begin
                // The aligning edge opens the window but is not counted.
                if (wdog_take)    state_d = S_FLUSH;
                else if (abort_i) state_d = S_FLUSH;
                else if (rise)    state_d = S_INTEG;
            end
            S_INTEG: begin
                if (cnt_finished_i) begin
                    state_d = S_CLEAR;
                    ok_d    = 1'b1;
                end else if (wdog_take || abort_i) begin
                    state_d = S_FLUSH;
                end else if (rise) begin
                    inc_d = 1'b1;
                end
            end
            S_FLUSH: begin
                if (cnt_finished_i) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d == S_FLUSH) ok_d = 1'b0;

        // Keep pushing the counter toward its wrap point. The count we see
        // lags our pulse by a clock, so one extra pulse lands on 24 and is
        // swallowed by the counter's unconditional 24->0 wrap.
        if ((state_d == S_FLUSH) && (cnt_count_i != CNT_FULL)) inc_d = 1'b1;

        integ_d = (state_d == S_INTEG);
        clr_d   = (state_d == S_CLEAR);
        busy_d  = (state_d != S_IDLE);

        done_d = done_q;
        if ((state_q == S_CLEAR) && ok_q) begin
            done_d = 1'b1;
        end else if (irq_ack_i || arm_entry) begin
            done_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            zc_q    <= 1'b0;
            ok_q    <= 1'b0;
            inc_q   <= 1'b0;
            clr_q   <= 1'b0;
            integ_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            zc_q    <= zero_cross_i;
            ok_q    <= ok_d;
            inc_q   <= inc_d;
            clr_q   <= clr_d;
            integ_q <= integ_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign cnt_increment_o = inc_q;
    assign cnt_clear_o     = clr_q;
    assign integrate_o     = integ_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;

endmodule

// File: tb/tb_measurement_sequencer.sv
module tb_measurement_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, abort, irq_ack, zc;
    logic [4:0] cnt;
    logic       fin;
    logic       inc, clr, integ, busy, done, err;
    logic [5:0] outs;

    int n_chk = 0;
    int n_pass = 0;
    int applied = 0;
    int inc_pulses = 0;
    int clr_pulses = 0;
    int integ_cyc = 0;

    always #5 clk = ~clk;

    measurement_sequencer #(.WDOG_W(8), .WDOG_LIMIT(50)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .abort_i        (abort),
        .irq_ack_i      (irq_ack),
        .zero_cross_i   (zc),
        .cnt_count_i    (cnt),
        .cnt_finished_i (fin),
        .cnt_increment_o(inc),
        .cnt_clear_o    (clr),
        .integrate_o    (integ),
        .busy_o         (busy),
        .done_o         (done),
        .err_o          (err)
    );

    assign outs = {inc, clr, integ, busy, done, err};

    // Line-cycle counter the sequencer drives, plus pulse monitors.
    // 'applied' counts increments that actually advanced the count.
    always @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            fin <= 1'b0;
        end else begin
            if (cnt == 5'd24) cnt <= '0;
            else if (inc) begin
                cnt     <= cnt + 5'd1;
                applied <= applied + 1;
            end
            if (clr) fin <= 1'b0;
            else if (cnt == 5'd24) fin <= 1'b1;
        end
        inc_pulses <= inc_pulses + int'(inc);
        clr_pulses <= clr_pulses + int'(clr);
        integ_cyc  <= integ_cyc + int'(integ);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("arm_busy", busy, 1);
        chk("arm_done_clr", done, 0);
        chk("arm_err_clr", err, 0);
    endtask

    // Called on the first negedge after the clock that took the FLUSH;
    // exp_t is the negedge index at which busy_o must first read 0.
    task automatic wait_idle(input string tag, input int exp_t);
        int t;
        t = 1;
        while (busy && t < 80) begin
            cyc();
            t++;
        end
        chk(tag, t, exp_t);
    endtask

    // Full measurement: 25 rising edges, edge 1 aligns, edges 2..25 counted.
    task automatic nominal(input int period, input bit ack_same, input bit abort_fin,
                           input bit start_busy, input bit do_irq);
        int c, h, edges, a0, i0, c0, g0;
        bit rn;
        h = period / 2;
        a0 = applied; i0 = inc_pulses; c0 = clr_pulses; g0 = integ_cyc;
        zc = 1'b0;
        do_start();
        c = 0; edges = 0;
        while (edges < 25) begin
            rn = ((c % period) == h);
            zc = ((c % period) >= h);
            if (rn) edges++;
            if (rn && edges == 1) chk("integ_pre", integ, 0);
            start = start_busy && rn && (edges == 5);
            cyc();
            c++;
            if (rn && edges == 1) chk("integ_rise", integ, 1);
        end
        start = 1'b0;
        zc = 1'b0;
        cyc();                       // +2 after edge 25 was set
        cyc();                       // +3: finished visible
        chk("fin_seen", fin, 1);
        chk("integ_hold", integ, 1);
        abort = abort_fin;
        cyc();                       // +4: CLEAR
        abort = 1'b0;
        chk("clr_pulse", clr, 1);
        chk("integ_fall", integ, 0);
        chk("busy_clear", busy, 1);
        irq_ack = ack_same;
        cyc();                       // +5: done
        irq_ack = 1'b0;
        chk("done_set", done, 1);
        chk("busy_end", busy, 0);
        chk("applied24", applied - a0, 24);
        chk("inc_total", inc_pulses - i0, 24);
        chk("clr_total", clr_pulses - c0, 1);
        chk("integ_len", integ_cyc - g0, 24 * period + 3);
        chk("cnt_zero", cnt, 0);
        chk("fin_zero", fin, 0);
        if (do_irq) begin
            irq_ack = 1'b1;
            cyc();
            irq_ack = 1'b0;
            chk("irq_done", done, 0);
        end
    endtask

    // Abort after K counted edges; optionally on the same clock as a rise.
    task automatic abort_run(input int period, input int k, input bit with_rise);
        int c, h, edges, a0, i0, c0;
        h = period / 2;
        a0 = applied; i0 = inc_pulses; c0 = clr_pulses;
        zc = 1'b0;
        do_start();
        c = 0; edges = 0;
        while (edges < k + 1) begin
            zc = ((c % period) >= h);
            if ((c % period) == h) edges++;
            cyc();
            c++;
        end
        if (with_rise) begin
            while ((c % period) != h) begin
                zc = ((c % period) >= h);
                cyc();
                c++;
            end
            zc = 1'b1;
        end else begin
            repeat (3) begin
                zc = ((c % period) >= h);
                cyc();
                c++;
            end
        end
        chk("cnt_at_abort", cnt, k);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("abort_integ", integ, 0);
        chk("abort_busy", busy, 1);
        wait_idle("abort_idle_t", 28 - k);
        zc = 1'b0;
        chk("abort_applied", applied - a0, 24);
        chk("abort_inc_total", inc_pulses - i0, 25);
        chk("abort_clr", clr_pulses - c0, 1);
        chk("abort_done", done, 0);
        chk("abort_err", err, 0);
        chk("abort_cnt", cnt, 0);
        chk("abort_fin", fin, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int a0, c0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; irq_ack = 1'b0; zc = 1'b0;
        cyc();
        cyc();
        chk("rst_outs", outs, 0);
        rst = 1'b0;
        cyc();
        chk("idle_outs", outs, 0);

        nominal($urandom_range(24, 4), 1'b0, 1'b0, 1'b0, 1'b1);
        nominal($urandom_range(24, 4), 1'b1, 1'b0, 1'b0, 1'b1);
        nominal($urandom_range(24, 4), 1'b0, 1'b1, 1'b0, 1'b0);
        nominal($urandom_range(24, 4), 1'b0, 1'b0, 1'b1, 1'b1);

        abort_run($urandom_range(20, 8), 10, 1'b0);
        abort_run($urandom_range(20, 8), $urandom_range(23, 1), 1'b1);

`ifdef MEAS_SEQ_WATCHDOG_EN
        a0 = applied; c0 = clr_pulses;
        do_start();
        for (int t = 1; t < 51; t++) begin
            if (t == 50) chk("wdog_pre", err, 0);
            cyc();
        end
        chk("wdog_err", err, 1);
        chk("wdog_integ", integ, 0);
        wait_idle("wdog_idle_t", 28);
        chk("wdog_applied", applied - a0, 24);
        chk("wdog_clr", clr_pulses - c0, 1);
        chk("wdog_err_sticky", err, 1);
        chk("wdog_done", done, 0);
        irq_ack = 1'b1;
        cyc();
        irq_ack = 1'b0;
        chk("wdog_irq", err, 0);
`else
        a0 = applied;
        do_start();
        repeat (1000) cyc();
        chk("nowd_busy", busy, 1);
        chk("nowd_err", err, 0);
        chk("nowd_integ", integ, 0);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        wait_idle("nowd_idle_t", 28);
        chk("nowd_applied", applied - a0, 24);
`endif

        // start and abort together in IDLE: the start wins
        a0 = applied;
        start = 1'b1; abort = 1'b1;
        cyc();
        start = 1'b0; abort = 1'b0;
        chk("sa_busy", busy, 1);
        cyc();
        chk("sa_still_arm", busy, 1);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        wait_idle("sa_idle_t", 28);
        chk("sa_applied", applied - a0, 24);

        // reset on edge 12 of a run
        begin
            int c, h, edges, p;
            p = $urandom_range(16, 6);
            h = p / 2;
            do_start();
            c = 0; edges = 0;
            while (edges < 12) begin
                zc = ((c % p) >= h);
                if ((c % p) == h) edges++;
                if (edges == 12) rst = 1'b1;
                cyc();
                c++;
            end
            rst = 1'b0;
            chk("mid_rst_outs", outs, 0);
            chk("mid_rst_cnt", cnt, 0);
            zc = 1'b0;
            cyc();
            chk("mid_rst_idle", busy, 0);
        end
        nominal($urandom_range(24, 4), 1'b0, 1'b0, 1'b0, 1'b1);

        repeat (3) begin
            nominal($urandom_range(24, 4), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                    1'($urandom_range(1, 0)), 1'b1);
            repeat ($urandom_range(5, 0)) cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/measurement_sequencer.md
# measurement_sequencer

Controls one voltmeter measurement: arms on a start request, aligns to a line-voltage zero crossing, and holds the integration window open for exactly 24 counted line cycles. It drives the 24-cycle line-cycle counter's increment and clear inputs and raises a sticky completion or error flag. On abort or watchdog timeout it flushes the counter back to a clean zero state. It sits between the host control/interrupt interface and the cycle counter and integrator front end.

## Interface
- WDOG_W, 20: watchdog counter width in bits.
- WDOG_LIMIT, 1000000: maximum number of clocks allowed between zero-crossing rising edges in ARM or INTEGRATE; must fit in WDOG_W bits.
- clk_i  input  1  system clock.
- rst_i  input  1  reset; one clock, synchronous, active-high.
- start_i  input  1  start request; sampled in IDLE only.
- abort_i  input  1  abort request; sampled in ARM and INTEGRATE only.
- irq_ack_i  input  1  clears done_o and err_o.
- zero_cross_i  input  1  comparator level, already synchronized to clk_i; a rising edge marks a line-cycle boundary.
- cnt_count_i  input  5  current count from the cycle counter (0–24).
- cnt_finished_i  input  1  finished flag from the cycle counter.
- cnt_increment_o  output  1  one-clock pulse that advances the counter.
- cnt_clear_o  output  1  one-clock pulse that clears the counter's finished flag.
- integrate_o  output  1  integration window enable.
- busy_o  output  1  high in any state other than IDLE.
- done_o  output  1  sticky flag: measurement completed.
- err_o  output  1  sticky flag: watchdog timeout occurred.

## Operation
- States: IDLE, ARM, INTEGRATE, FLUSH, CLEAR.
- All outputs are registered; every output resets to 0.
- The FSM resets to IDLE; the internal zero-crossing delay register resets to 0.
- Edge detect: rise = zero_cross_i & ~zc_q, where zc_q is zero_cross_i delayed one clock.
- IDLE
  - start_i=1: go to ARM.
  - Entering ARM clears done_o and err_o.
- ARM
  - rise: go to INTEGRATE. This first edge is not counted.
  - abort_i=1: go to FLUSH.
- INTEGRATE
  - integrate_o=1 for the whole state.
  - Each rise produces one cnt_increment_o pulse.
  - cnt_finished_i=1: go to CLEAR and set an internal ok flag.
  - abort_i=1 with cnt_finished_i=0: go to FLUSH.
- FLUSH
  - integrate_o=0.
  - Drive cnt_increment_o=1 on every clock in which the registered value of cnt_count_i is not 24.
  - cnt_finished_i=1: go to CLEAR with ok=0.
- CLEAR
  - Lasts one clock; cnt_clear_o=1.
  - Then go to IDLE.
  - ok=1 sets done_o.
- Watchdog
  - Counts clocks in ARM and INTEGRATE; restarts at 0 on each rise and on entry to ARM.
  - Reaching WDOG_LIMIT sets err_o and forces FLUSH.
  - It saturates and does not count outside ARM and INTEGRATE.
- irq_ack_i clears done_o and err_o.
  - A flag being set in the same clock as irq_ack_i wins over the clear.
- Priorities:
  - In INTEGRATE: cnt_finished_i > watchdog > abort_i.
  - start_i and abort_i in the same clock in IDLE: the start is taken.
  - start_i while busy_o=1: ignored.
  - A rise in the same clock as abort_i: no increment is issued.
- Reset in the middle of a measurement:
  - The FSM returns to IDLE with all outputs 0 on the next clock.
  - The cycle counter must be reset in the same clock, so the system returns to a consistent zero state.

## Timing
- cnt_increment_o goes high 1 clock after the clock that samples a rise.
- integrate_o rises 1 clock after the ARM rise.
- integrate_o falls 1 clock after cnt_finished_i is first seen high.
- Counter-path latency after the 24th counted rise is sampled:
  - increment at +1;
  - cnt_count_i=24 at +2;
  - cnt_finished_i at +3;
  - CLEAR at +4;
  - done_o=1 and busy_o=0 at +5.
- Overshoot in FLUSH is harmless: the counter wraps from 24 to 0 regardless of increment.
- A FLUSH started from count 0 takes at most 27 clocks to reach IDLE.

## Configuration
- MEAS_SEQ_WATCHDOG_EN defined: the watchdog is implemented as specified.
- MEAS_SEQ_WATCHDOG_EN not defined: the watchdog logic is removed, err_o is tied to 0, and WDOG_W and WDOG_LIMIT are unused.
  - ARM and INTEGRATE then wait indefinitely for edges or abort_i.

## Test plan
- Nominal run: start pulse; zero_cross_i square wave with a 20-clock period and 25 rising edges.
  - Required: integrate_o high from 1 clock after edge 1 until cnt_finished_i.
  - Required: exactly 24 cnt_increment_o pulses and one cnt_clear_o pulse.
  - Required: done_o=1 and busy_o=0 five clocks after edge 25 is sampled.
  - Required: irq_ack_i then returns done_o to 0.
- Abort at count 10 in INTEGRATE.
  - Required: integrate_o=0 next clock.
  - Required: back-to-back increments until cnt_count_i=24, then one cnt_clear_o pulse, then IDLE.
  - Required: done_o=0, err_o=0, and the counter at 0 with finished=0.
- Watchdog (macro defined, WDOG_LIMIT=50): start, then no edges.
  - Required: err_o=1 at clock 50 after entry to ARM.
  - Required: FLUSH of 24 increments, then CLEAR, then IDLE.
  - Macro undefined: the FSM stays in ARM for 1000 clocks and err_o stays 0.
- Simultaneous events:
  - abort_i in the same clock as cnt_finished_i: done_o=1 and no FLUSH.
  - irq_ack_i in the same clock done_o is set: done_o stays 1.
  - start_i with abort_i in IDLE: enters ARM.
  - start_i while busy: ignored.
- Mid-run reset: rst_i pulsed at edge 12 of a run.
  - Required: all outputs 0 on the next clock and the FSM in IDLE.
  - Required: a following nominal run passes.
